hazard_ctrl: RTL and testbench

Parametrised hazard and pipeline-control unit for the 5-stage MIPS CPU. It generalises per-stage forwarding, load-use stalling, branch flush and debug single-step. It adds three things:
- a multi-cycle EXE-unit busy interlock (mul/div) driven by a latency counter;
- a configurable branch-delay-slot mode;
- a saturating stall-cycle performance counter.

It takes hazard inputs from ID, EXE, MEM and WB. It drives the per-stage en/rst signals and the operand-forward selects that the datapath registers into EXE.

---
 rtl/hazard_pkg.sv | 31 +++
 rtl/hazard_ctrl_fwd_sel.sv | 33 +++
 rtl/hazard_ctrl.sv | 179 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/pipeline-control slice: forward selects,
// multi-cycle FSM states and the per-stage enable/clear bundle.
package hazard_pkg;

    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_EXE = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_e;

    typedef struct packed {
        logic if_en;
        logic id_en;
        logic exe_en;
        logic mem_en;
        logic wb_en;
        logic if_rst;
        logic id_rst;
        logic exe_rst;
        logic mem_rst;
        logic wb_rst;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN = '{if_en: 1'b1, id_en: 1'b1, exe_en: 1'b1,
                                   mem_en: 1'b1, wb_en: 1'b1, default: 1'b0};

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Per-source operand forward resolver; youngest matching producer wins and
// register $0 is never forwarded.
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int unsigned ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] src_addr_i,
    input  logic              exe_wen_i,
    input  logic [ADDR_W-1:0] exe_waddr_i,
    input  logic              exe_is_load_i,
    input  logic              mem_wen_i,
    input  logic [ADDR_W-1:0] mem_waddr_i,
    input  logic              wb_wen_i,
    input  logic [ADDR_W-1:0] wb_waddr_i,
    output logic [1:0]        sel_o
);

    always_comb begin
        sel_o = FWD_REG;
        if (src_addr_i != '0) begin
            // A load in EXE has no data yet; the stall or store path covers it.
            if (exe_wen_i && (exe_waddr_i == src_addr_i)) begin
                sel_o = exe_is_load_i ? FWD_REG : FWD_EXE;
            end else if (mem_wen_i && (mem_waddr_i == src_addr_i)) begin
                sel_o = FWD_MEM;
            end else if (wb_wen_i && (wb_waddr_i == src_addr_i)) begin
                sel_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage MIPS core: forwarding,
// load-use stall, branch flush, multi-cycle interlock, debug step, stall counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned MC_LAT     = 4,
    parameter int unsigned DELAY_SLOT = 0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              debug_en,
    input  logic              debug_step,
    input  logic [ADDR_W-1:0] id_rs_addr,
    input  logic [ADDR_W-1:0] id_rt_addr,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              id_is_store,
    input  logic              id_is_mc,
    input  logic              exe_wen,
    input  logic              mem_wen,
    input  logic              wb_wen,
    input  logic [ADDR_W-1:0] exe_waddr,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic              exe_is_load,
    input  logic              branch_taken_exe,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              fwd_store_m,
    output logic              if_en,
    output logic              id_en,
    output logic              exe_en,
    output logic              mem_en,
    output logic              wb_en,
    output logic              if_rst,
    output logic              id_rst,
    output logic              exe_rst,
    output logic              mem_rst,
    output logic              wb_rst,
    output logic              mc_busy,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam int unsigned MC_CNT_W = $clog2(MC_LAT);

    mc_state_e            state_q;
    logic [MC_CNT_W-1:0]  mc_cnt_q;
    logic                 step_prev_q;
    logic [CNT_W-1:0]     stall_q;

    logic [1:0] a_sel;
    logic [1:0] b_sel;
    logic       exe_ld_prod;
    logic       lu_hit;
    logic       store_hit;
    logic       freeze;
    logic       stall_evt;
    logic       mc_issue;
    ctrl_t      ctrl;

    fwd_sel #(.ADDR_W(ADDR_W)) u_fwd_rs (
        .src_addr_i   (id_rs_addr),
        .exe_wen_i    (exe_wen),
        .exe_waddr_i  (exe_waddr),
        .exe_is_load_i(exe_is_load),
        .mem_wen_i    (mem_wen),
        .mem_waddr_i  (mem_waddr),
        .wb_wen_i     (wb_wen),
        .wb_waddr_i   (wb_waddr),
        .sel_o        (a_sel)
    );

    fwd_sel #(.ADDR_W(ADDR_W)) u_fwd_rt (
        .src_addr_i   (id_rt_addr),
        .exe_wen_i    (exe_wen),
        .exe_waddr_i  (exe_waddr),
        .exe_is_load_i(exe_is_load),
        .mem_wen_i    (mem_wen),
        .mem_waddr_i  (mem_waddr),
        .wb_wen_i     (wb_wen),
        .wb_waddr_i   (wb_waddr),
        .sel_o        (b_sel)
    );

    assign exe_ld_prod = exe_is_load && exe_wen && (exe_waddr != '0);
    assign lu_hit      = exe_ld_prod &&
                         ((id_rs_used && (id_rs_addr == exe_waddr)) ||
                          (id_rt_used && (id_rt_addr == exe_waddr) && !id_is_store));
    assign store_hit   = exe_ld_prod && id_is_store && (id_rt_addr == exe_waddr);
    assign freeze      = debug_en && !(debug_step && !step_prev_q);

    always_comb begin
        ctrl      = CTRL_RUN;
        stall_evt = 1'b0;
        mc_issue  = 1'b0;
        if (!rst_n) begin
            ctrl.if_rst  = 1'b1;
            ctrl.id_rst  = 1'b1;
            ctrl.exe_rst = 1'b1;
            ctrl.mem_rst = 1'b1;
            ctrl.wb_rst  = 1'b1;
        end else if (freeze) begin
            ctrl.if_en  = 1'b0;
            ctrl.id_en  = 1'b0;
            ctrl.exe_en = 1'b0;
            ctrl.mem_en = 1'b0;
            ctrl.wb_en  = 1'b0;
        end else if (state_q == MC_BUSY) begin
            ctrl.if_en   = 1'b0;
            ctrl.id_en   = 1'b0;
            ctrl.exe_en  = 1'b0;
            ctrl.mem_rst = 1'b1;
            stall_evt    = 1'b1;
        end else if (branch_taken_exe) begin
            ctrl.id_rst = 1'b1;
            if (DELAY_SLOT == 0) begin
                ctrl.exe_rst = 1'b1;
            end
        end else if (lu_hit) begin
            ctrl.if_en   = 1'b0;
            ctrl.id_en   = 1'b0;
            ctrl.exe_rst = 1'b1;
            stall_evt    = 1'b1;
        end else begin
            mc_issue = id_is_mc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= MC_IDLE;
            mc_cnt_q    <= '0;
            step_prev_q <= 1'b0;
            stall_q     <= '0;
        end else begin
            step_prev_q <= debug_step;
            if (!freeze) begin
                case (state_q)
                    MC_IDLE: begin
                        if (mc_issue) begin
                            state_q  <= MC_BUSY;
                            mc_cnt_q <= MC_CNT_W'(MC_LAT - 2);
                        end
                    end
                    MC_BUSY: begin
                        if (mc_cnt_q == '0) begin
                            state_q <= MC_IDLE;
                        end else begin
                            mc_cnt_q <= mc_cnt_q - MC_CNT_W'(1);
                        end
                    end
                    default: state_q <= MC_IDLE;
                endcase
                if (stall_evt && (stall_q != '1)) begin
                    stall_q <= stall_q + CNT_W'(1);
                end
            end
        end
    end

    assign fwd_a_sel    = rst_n ? a_sel : FWD_REG;
    assign fwd_b_sel    = rst_n ? b_sel : FWD_REG;
    assign fwd_store_m  = rst_n && store_hit;
    assign if_en        = ctrl.if_en;
    assign id_en        = ctrl.id_en;
    assign exe_en       = ctrl.exe_en;
    assign mem_en       = ctrl.mem_en;
    assign wb_en        = ctrl.wb_en;
    assign if_rst       = ctrl.if_rst;
    assign id_rst       = ctrl.id_rst;
    assign exe_rst      = ctrl.exe_rst;
    assign mem_rst      = ctrl.mem_rst;
    assign wb_rst       = ctrl.wb_rst;
    assign mc_busy      = (state_q == MC_BUSY);
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: table of single-cycle vectors plus
// hand-written multi-cycle sequences (mc interlock, debug step, reset, saturation).
module tb_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic        debug_en, debug_step;
    logic [4:0]  id_rs_addr, id_rt_addr;
    logic        id_rs_used, id_rt_used, id_is_store, id_is_mc;
    logic        exe_wen, mem_wen, wb_wen;
    logic [4:0]  exe_waddr, mem_waddr, wb_waddr;
    logic        exe_is_load, branch_taken_exe;

    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        fwd_store_m;
    logic        if_en, id_en, exe_en, mem_en, wb_en;
    logic        if_rst, id_rst, exe_rst, mem_rst, wb_rst;
    logic        mc_busy;
    logic [15:0] stall_cycles;

    logic [1:0]  d1_fwd_a_sel, d1_fwd_b_sel;
    logic        d1_fwd_store_m;
    logic        d1_if_en, d1_id_en, d1_exe_en, d1_mem_en, d1_wb_en;
    logic        d1_if_rst, d1_id_rst, d1_exe_rst, d1_mem_rst, d1_wb_rst;
    logic        d1_mc_busy;
    logic [1:0]  d1_stall_cycles;

    int total = 0;
    int bad   = 0;

    hazard_ctrl #(.ADDR_W(5), .MC_LAT(4), .DELAY_SLOT(0), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .debug_en(debug_en), .debug_step(debug_step),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_is_store(id_is_store), .id_is_mc(id_is_mc),
        .exe_wen(exe_wen), .mem_wen(mem_wen), .wb_wen(wb_wen),
        .exe_waddr(exe_waddr), .mem_waddr(mem_waddr), .wb_waddr(wb_waddr),
        .exe_is_load(exe_is_load), .branch_taken_exe(branch_taken_exe),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .fwd_store_m(fwd_store_m),
        .if_en(if_en), .id_en(id_en), .exe_en(exe_en), .mem_en(mem_en), .wb_en(wb_en),
        .if_rst(if_rst), .id_rst(id_rst), .exe_rst(exe_rst), .mem_rst(mem_rst),
        .wb_rst(wb_rst), .mc_busy(mc_busy), .stall_cycles(stall_cycles)
    );

    hazard_ctrl #(.ADDR_W(5), .MC_LAT(4), .DELAY_SLOT(1), .CNT_W(2)) dut_ds (
        .clk(clk), .rst_n(rst_n), .debug_en(debug_en), .debug_step(debug_step),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_is_store(id_is_store), .id_is_mc(id_is_mc),
        .exe_wen(exe_wen), .mem_wen(mem_wen), .wb_wen(wb_wen),
        .exe_waddr(exe_waddr), .mem_waddr(mem_waddr), .wb_waddr(wb_waddr),
        .exe_is_load(exe_is_load), .branch_taken_exe(branch_taken_exe),
        .fwd_a_sel(d1_fwd_a_sel), .fwd_b_sel(d1_fwd_b_sel), .fwd_store_m(d1_fwd_store_m),
        .if_en(d1_if_en), .id_en(d1_id_en), .exe_en(d1_exe_en), .mem_en(d1_mem_en),
        .wb_en(d1_wb_en), .if_rst(d1_if_rst), .id_rst(d1_id_rst), .exe_rst(d1_exe_rst),
        .mem_rst(d1_mem_rst), .wb_rst(d1_wb_rst), .mc_busy(d1_mc_busy),
        .stall_cycles(d1_stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       rs_u;
        logic       rt_u;
        logic       st;
        logic       ew;
        logic [4:0] ea;
        logic       el;
        logic       mw;
        logic [4:0] ma;
        logic       ww;
        logic [4:0] wa;
        logic       br;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       sm;
        logic [4:0] en;   // {if,id,exe,mem,wb}
        logic [4:0] rst;  // {if,id,exe,mem,wb}
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        debug_en = 0; debug_step = 0;
        id_rs_addr = 0; id_rt_addr = 0; id_rs_used = 0; id_rt_used = 0;
        id_is_store = 0; id_is_mc = 0;
        exe_wen = 0; mem_wen = 0; wb_wen = 0;
        exe_waddr = 0; mem_waddr = 0; wb_waddr = 0;
        exe_is_load = 0; branch_taken_exe = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        clear_inputs();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic set_load_use();
        exe_is_load = 1; exe_wen = 1; exe_waddr = 5;
        id_rs_addr = 5; id_rt_addr = 1; id_rs_used = 1; id_rt_used = 1;
    endtask

    initial begin
        //          rs rt ru tu st ew ea el mw ma ww wa br fa fb sm en        rst
        vecs[0]  = '{3, 3, 1, 1, 0, 1, 3, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5'b11111, 5'b00000};
        vecs[1]  = '{3, 3, 1, 1, 0, 0, 3, 0, 1, 3, 0, 0, 0, 2, 2, 0, 5'b11111, 5'b00000};
        vecs[2]  = '{3, 3, 1, 1, 0, 0, 0, 0, 0, 0, 1, 3, 0, 3, 3, 0, 5'b11111, 5'b00000};
        vecs[3]  = '{0, 0, 1, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 5'b11111, 5'b00000};
        vecs[4]  = '{3, 3, 1, 1, 0, 1, 3, 0, 1, 3, 1, 3, 0, 1, 1, 0, 5'b11111, 5'b00000};
        vecs[5]  = '{3, 3, 1, 1, 0, 0, 0, 0, 1, 3, 1, 3, 0, 2, 2, 0, 5'b11111, 5'b00000};
        vecs[6]  = '{3, 7, 1, 1, 0, 1, 3, 0, 1, 9, 1, 7, 0, 1, 3, 0, 5'b11111, 5'b00000};
        vecs[7]  = '{5, 1, 1, 1, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00111, 5'b00100};
        vecs[8]  = '{2, 5, 1, 1, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11111, 5'b00000};
        vecs[9]  = '{5, 2, 1, 1, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00111, 5'b00100};
        vecs[10] = '{5, 5, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 5'b00000};
        vecs[11] = '{0, 0, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 5'b00000};
        vecs[12] = '{5, 1, 1, 1, 0, 1, 5, 1, 0, 0, 0, 0, 1, 0, 0, 0, 5'b11111, 5'b01100};
        vecs[13] = '{5, 1, 1, 1, 0, 0, 5, 1, 1, 5, 0, 0, 0, 2, 0, 0, 5'b11111, 5'b00000};
        vecs[14] = '{1, 5, 0, 1, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00111, 5'b00100};

        rst_n = 0;
        clear_inputs();

        // Reset: outputs forced regardless of hazard inputs.
        @(negedge clk);
        set_load_use();
        branch_taken_exe = 1;
        #1;
        chk("rst_en",  {if_en, id_en, exe_en, mem_en, wb_en}, 5'b11111);
        chk("rst_rst", {if_rst, id_rst, exe_rst, mem_rst, wb_rst}, 5'b11111);
        chk("rst_fwd", {fwd_a_sel, fwd_b_sel, fwd_store_m}, 5'b00000);
        @(negedge clk);
        #1;
        chk("rst_busy",  mc_busy, 0);
        chk("rst_stall", stall_cycles, 0);
        clear_inputs();
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            id_rs_addr = vecs[i].rs;  id_rt_addr = vecs[i].rt;
            id_rs_used = vecs[i].rs_u; id_rt_used = vecs[i].rt_u;
            id_is_store = vecs[i].st;
            exe_wen = vecs[i].ew; exe_waddr = vecs[i].ea; exe_is_load = vecs[i].el;
            mem_wen = vecs[i].mw; mem_waddr = vecs[i].ma;
            wb_wen = vecs[i].ww;  wb_waddr = vecs[i].wa;
            branch_taken_exe = vecs[i].br;
            #1;
            chk($sformatf("v%0d_fa", i), fwd_a_sel, vecs[i].fa);
            chk($sformatf("v%0d_fb", i), fwd_b_sel, vecs[i].fb);
            chk($sformatf("v%0d_sm", i), fwd_store_m, vecs[i].sm);
            chk($sformatf("v%0d_en", i), {if_en, id_en, exe_en, mem_en, wb_en}, vecs[i].en);
            chk($sformatf("v%0d_rst", i), {if_rst, id_rst, exe_rst, mem_rst, wb_rst}, vecs[i].rst);
        end

        // Load-use bubble, then MEM forwarding with counter at 1.
        do_reset();
        set_load_use();
        #1;
        chk("lu_en", {if_en, id_en, exe_en, mem_en, wb_en}, 5'b00111);
        chk("lu_exe_rst", exe_rst, 1);
        @(negedge clk);
        exe_is_load = 0; exe_wen = 0; mem_wen = 1; mem_waddr = 5;
        #1;
        chk("lu_next_fa", fwd_a_sel, 2);
        chk("lu_next_en", {if_en, id_en, exe_en, mem_en, wb_en}, 5'b11111);
        chk("lu_stall1", stall_cycles, 1);

        // Multi-cycle op: 3 busy cycles, counter +3, then saturation on narrow counter.
        do_reset();
        id_is_mc = 1;
        #1;
        chk("mc_issue_busy", mc_busy, 0);
        chk("mc_issue_en", {if_en, id_en, exe_en, mem_en, wb_en}, 5'b11111);
        @(negedge clk);
        id_is_mc = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("mc_busy%0d", k), mc_busy, 1);
            chk($sformatf("mc_en%0d", k), {if_en, id_en, exe_en, mem_en, wb_en}, 5'b00011);
            chk($sformatf("mc_rst%0d", k), {if_rst, id_rst, exe_rst, mem_rst, wb_rst}, 5'b00010);
            @(negedge clk);
        end
        #1;
        chk("mc_done_busy", mc_busy, 0);
        chk("mc_stall3", stall_cycles, 3);
        chk("mc_ds_stall3", d1_stall_cycles, 3);
        @(negedge clk);
        set_load_use();
        @(negedge clk);
        clear_inputs();
        #1;
        chk("stall4", stall_cycles, 4);
        chk("sat_stall", d1_stall_cycles, 3);

        // Reset in the middle of a multi-cycle op aborts it.
        do_reset();
        id_is_mc = 1;
        @(negedge clk);
        id_is_mc = 0;
        #1;
        chk("mcr_busy", mc_busy, 1);
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("mcr_abort", mc_busy, 0);

        // Branch flush overrides load-use; delay-slot variant clears ID only.
        do_reset();
        set_load_use();
        branch_taken_exe = 1;
        #1;
        chk("br0_en",  {if_en, id_en, exe_en, mem_en, wb_en}, 5'b11111);
        chk("br0_rst", {if_rst, id_rst, exe_rst, mem_rst, wb_rst}, 5'b01100);
        chk("br1_en",  {d1_if_en, d1_id_en, d1_exe_en, d1_mem_en, d1_wb_en}, 5'b11111);
        chk("br1_rst", {d1_if_rst, d1_id_rst, d1_exe_rst, d1_mem_rst, d1_wb_rst}, 5'b01000);
        @(negedge clk);
        clear_inputs();
        #1;
        chk("br_nostall", stall_cycles, 0);

        // Debug freeze, single step, and FSM hold while frozen.
        do_reset();
        debug_en = 1; debug_step = 1;
        @(negedge clk);
        id_is_mc = 1;
        #1;
        chk("dbg_frz0", {if_en, id_en, exe_en, mem_en, wb_en}, 5'b00000);
        @(negedge clk);
        debug_step = 0;
        #1;
        chk("dbg_frz1", {if_en, id_en, exe_en, mem_en, wb_en}, 5'b00000);
        chk("dbg_noissue", mc_busy, 0);
        @(negedge clk);
        debug_step = 1;
        #1;
        chk("dbg_step", {if_en, id_en, exe_en, mem_en, wb_en}, 5'b11111);
        @(negedge clk);
        id_is_mc = 0;
        #1;
        chk("dbg_after", {if_en, id_en, exe_en, mem_en, wb_en}, 5'b00000);
        chk("dbg_busy0", mc_busy, 1);
        @(negedge clk);
        #1;
        chk("dbg_hold", mc_busy, 1);
        chk("dbg_stall_hold", stall_cycles, 0);
        @(negedge clk);
        debug_en = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("dbg_mc%0d", k), mc_busy, 1);
            @(negedge clk);
        end
        #1;
        chk("dbg_mc_done", mc_busy, 0);
        chk("dbg_stall3", stall_cycles, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
